// File: rtl/led_mode_ctrl.sv
// Button front-end for the 8-LED chaser: sync, debounce, mode toggle, change pulse, step divider.
// Optional long-press clear is enabled by defining LED_MODE_LONGPRESS_EN.
module led_mode_ctrl #(
`ifdef LED_MODE_LONGPRESS_EN
    parameter int LONG_CNT = 32,
`endif
    parameter int DB_CNT   = 4,
    parameter int STEP_DIV = 8,
    parameter int CW       = 16
) (
    input  logic ck,
    input  logic rs,
    input  logic btn,
    output logic s,
    output logic step,
`ifdef LED_MODE_LONGPRESS_EN
    output logic clr,
`endif
    output logic chg
);

    localparam logic [CW-1:0] DB_TC  = CW'(DB_CNT - 1);
    localparam logic [CW-1:0] DIV_TC = CW'(STEP_DIV - 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic [CW-1:0] div_q, div_d;
    logic          s_q, s_d;
    logic          step_q, step_d;
    logic          chg_q, chg_d;
    logic          rise;

`ifdef LED_MODE_LONGPRESS_EN
    localparam logic [CW-1:0] LONG_TC = CW'(LONG_CNT - 1);
    logic [CW-1:0] lcnt_q, lcnt_d;
    logic          clr_q, clr_d;
`endif

    always_comb begin
        db_d   = db_q;
        dcnt_d = dcnt_q;
        rise   = 1'b0;
        if (sync2_q == db_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DB_TC) begin
            db_d   = sync2_q;
            dcnt_d = '0;
            rise   = sync2_q;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end

        s_d   = s_q;
        chg_d = 1'b0;
        if (rise) begin
            s_d   = ~s_q;
            chg_d = 1'b1;
        end

`ifdef LED_MODE_LONGPRESS_EN
        // lcnt parks one past the terminal count so a long hold clears only once
        lcnt_d = lcnt_q;
        clr_d  = 1'b0;
        if (!db_q) begin
            lcnt_d = '0;
        end else if (lcnt_q == LONG_TC) begin
            lcnt_d = lcnt_q + 1'b1;
            clr_d  = 1'b1;
            s_d    = 1'b0;
            chg_d  = s_q;
        end else if (lcnt_q < LONG_TC) begin
            lcnt_d = lcnt_q + 1'b1;
        end
`endif

        // a mode change restarts the step phase and suppresses a coincident step
        if (chg_d) begin
            div_d  = '0;
            step_d = 1'b0;
        end else begin
            step_d = (div_q == DIV_TC);
            div_d  = (div_q == DIV_TC) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (rs) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            dcnt_q  <= '0;
            div_q   <= '0;
            s_q     <= 1'b0;
            step_q  <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            dcnt_q  <= dcnt_d;
            div_q   <= div_d;
            s_q     <= s_d;
            step_q  <= step_d;
            chg_q   <= chg_d;
        end
    end

`ifdef LED_MODE_LONGPRESS_EN
    always_ff @(posedge ck) begin
        if (rs) begin
            lcnt_q <= '0;
            clr_q  <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            clr_q  <= clr_d;
        end
    end

    assign clr = clr_q;
`endif

    assign s    = s_q;
    assign step = step_q;
    assign chg  = chg_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed self-checking bench for led_mode_ctrl with default parameters (DB_CNT=4, STEP_DIV=8).
module tb_led_mode_ctrl;

    logic ck = 1'b0;
    logic rs;
    logic btn;
    logic s, step, chg;
`ifdef LED_MODE_LONGPRESS_EN
    logic clr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 ck = ~ck;

    led_mode_ctrl dut (
        .ck   (ck),
        .rs   (rs),
        .btn  (btn),
        .s    (s),
        .step (step),
`ifdef LED_MODE_LONGPRESS_EN
        .clr  (clr),
`endif
        .chg  (chg)
    );

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_sc(input string tag, input logic es, input logic ec);
        chk($sformatf("%s.s", tag), s, es);
        chk($sformatf("%s.chg", tag), chg, ec);
    endtask

    task automatic chk3(input string tag, input logic es, input logic est, input logic ec);
        chk_sc(tag, es, ec);
        chk($sformatf("%s.step", tag), step, est);
    endtask

    initial begin
        // reset held three edges with the button pressed
        rs  = 1'b1;
        btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk3($sformatf("rst%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // idle: step after edges 8, 16, 24
        rs  = 1'b0;
        btn = 1'b0;
        for (int n = 1; n <= 24; n++) begin
            tick();
            chk3($sformatf("idle%0d", n), 1'b0, (n % 8) == 0, 1'b0);
        end

        // clean press held 10 edges: toggle at k+5, step re-phased to k+13, release ignored
        btn = 1'b1;
        for (int j = 0; j <= 24; j++) begin
            tick();
            if (j == 9) btn = 1'b0;
            chk3($sformatf("press%0d", j), j >= 5, (j == 13) || (j == 21), j == 5);
        end

        // bounce: 2-edge pulses never qualify
        for (int b = 0; b < 12; b++) begin
            btn = (b % 4) < 2;
            tick();
            chk_sc($sformatf("bounce%0d", b), 1'b1, 1'b0);
        end
        btn = 1'b1;
        for (int j = 0; j <= 14; j++) begin
            tick();
            chk_sc($sformatf("settle%0d", j), j < 5, j == 5);
            if (j >= 5) chk($sformatf("settle%0d.step", j), step, j == 13);
        end

        // release, then two presses 20 edges apart
        btn = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk_sc($sformatf("rel%0d", j), 1'b0, 1'b0);
        end
        btn = 1'b1;
        for (int j = 0; j <= 34; j++) begin
            tick();
            if (j == 7)  btn = 1'b0;
            if (j == 19) btn = 1'b1;
            if (j == 27) btn = 1'b0;
            chk3($sformatf("two%0d", j), (j >= 5) && (j < 25),
                 (j == 13) || (j == 21) || (j == 33), (j == 5) || (j == 25));
        end

        // reset with dcnt=2 and div=5
        btn = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk3($sformatf("pre%0d", j), 1'b0, 1'b0, 1'b0);
        end
        rs = 1'b1;
        tick();
        chk3("midrst", 1'b0, 1'b0, 1'b0);
        rs = 1'b0;
        for (int j = 0; j <= 13; j++) begin
            tick();
            chk3($sformatf("post%0d", j), j >= 5, j == 13, j == 5);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
